// File: rtl/cdc_fifo_pkg.sv
// Shared constants for the CDC FIFO read-side output stage.
package cdc_fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned BUF_DEPTH      = 2;
  localparam int unsigned COUNT_W        = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PTR_W          = 1;

endpackage

// File: rtl/cdc_fifo_skid_buffer.sv
// Two-entry registered FIFO that absorbs in-flight memory words while the consumer stalls.
module cdc_fifo_skid_buffer
  import cdc_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic [COUNT_W-1:0]    o_count
);

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [COUNT_W-1:0]    r_count;
  logic                  w_pop;

  // A pop is only honoured when a word is actually buffered.
  assign w_pop   = i_pop & o_valid;
  assign o_data  = r_mem[r_head];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_push_data;
        r_tail        <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_count <= r_count + COUNT_W'(i_push) - COUNT_W'(w_pop);
    end
  end

endmodule

// File: rtl/cdc_fifo_read_stream.sv
// Read-domain output stage: pops the FIFO storage and presents words as a valid/ready stream.
module cdc_fifo_read_stream
  import cdc_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  empty,
  output logic                  increment,
  output logic                  mem_read_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COUNT_W-1:0]    out_count
);

  localparam int unsigned LEVEL_W = COUNT_W + 1;

  logic               r_inflight;
  logic               w_drain;
  logic [LEVEL_W-1:0] w_level;

  // Occupancy after this edge, before any new pop; a pop is allowed only if it leaves room.
  assign w_drain         = out_valid & out_ready;
  assign w_level         = LEVEL_W'(out_count) + LEVEL_W'(r_inflight) - LEVEL_W'(w_drain);
  assign increment       = ~empty & ~reset & (w_level < LEVEL_W'(BUF_DEPTH));
  assign mem_read_enable = increment;

  // The memory port is registered, so the popped word appears one cycle later.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= increment;
    end
  end

  cdc_fifo_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clock      (clock),
    .reset      (reset),
    .i_push     (r_inflight),
    .i_push_data(mem_read_data),
    .i_pop      (w_drain),
    .o_data     (out_data),
    .o_valid    (out_valid),
    .o_count    (out_count)
  );

endmodule
